// File: rtl/button_pkg.sv
// Shared state encoding and 48 MHz default timing for the push-button input path.
package button_pkg;

  typedef enum logic [2:0] {
    S_RELEASED,
    S_PRESS_DB,
    S_PRESSED,
    S_LONG,
    S_RELEASE_DB
  } button_state_t;

  localparam int DEFAULT_SYNC_STAGES       = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 480_000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 48_000_000;
  localparam int DEFAULT_ACTIVE_LOW        = 1;

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchroniser bringing an asynchronous pin into the clk_48MHz domain.
module input_synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_48MHz,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  // Reset loads the idle pin level so no phantom edge appears after reset.
  always_ff @(posedge clk_48MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/button_input_debouncer.sv
// Push-button conditioner: synchronise, debounce, and emit press/release/click/long-press pulses.
module button_input_debouncer
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int ACTIVE_LOW        = DEFAULT_ACTIVE_LOW
) (
  input  logic clk_48MHz,
  input  logic rst_n,
  input  logic iKEY,
  output logic oPressed,
  output logic oPressPulse,
  output logic oReleasePulse,
  output logic oShortClick,
  output logic oLongPress
);

  localparam logic PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int   DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int   HOLD_W   = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic          sync_out;
  logic          act;
  button_state_t state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic          long_seen;

  input_synchronizer #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (PIN_IDLE)
  ) u_sync (
    .clk_48MHz (clk_48MHz),
    .rst_n     (rst_n),
    .din       (iKEY),
    .dout      (sync_out)
  );

  assign act = (ACTIVE_LOW != 0) ? ~sync_out : sync_out;

  // A release seen on the hold terminal cycle takes priority over long-press.
  always_ff @(posedge clk_48MHz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_seen     <= 1'b0;
      oPressed      <= 1'b0;
      oPressPulse   <= 1'b0;
      oReleasePulse <= 1'b0;
      oShortClick   <= 1'b0;
      oLongPress    <= 1'b0;
    end else begin
      oPressPulse   <= 1'b0;
      oReleasePulse <= 1'b0;
      oShortClick   <= 1'b0;
      oLongPress    <= 1'b0;
      case (state)
        S_RELEASED: begin
          if (act) begin
            state  <= S_PRESS_DB;
            db_cnt <= '0;
          end
        end
        S_PRESS_DB: begin
          if (!act) begin
            state <= S_RELEASED;
          end else if (db_cnt == DB_LAST) begin
            state       <= S_PRESSED;
            oPressed    <= 1'b1;
            oPressPulse <= 1'b1;
            hold_cnt    <= '0;
            long_seen   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          if (!act) begin
            state  <= S_RELEASE_DB;
            db_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= S_LONG;
            oLongPress <= 1'b1;
            long_seen  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_LONG: begin
          if (!act) begin
            state  <= S_RELEASE_DB;
            db_cnt <= '0;
          end
        end
        S_RELEASE_DB: begin
          if (act) begin
            state <= long_seen ? S_LONG : S_PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state         <= S_RELEASED;
            oPressed      <= 1'b0;
            oReleasePulse <= 1'b1;
            oShortClick   <= ~long_seen;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= S_RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_input_debouncer.sv
// Directed self-checking bench for button_input_debouncer with short debounce/long-press timing.
module tb_button_input_debouncer;

  logic clk_48MHz;
  logic rst_n;
  logic iKEY;
  logic oPressed;
  logic oPressPulse;
  logic oReleasePulse;
  logic oShortClick;
  logic oLongPress;

  int total;
  int bad;

  button_input_debouncer #(
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (8),
    .LONG_PRESS_CYCLES (64),
    .ACTIVE_LOW        (1)
  ) dut (
    .clk_48MHz     (clk_48MHz),
    .rst_n         (rst_n),
    .iKEY          (iKEY),
    .oPressed      (oPressed),
    .oPressPulse   (oPressPulse),
    .oReleasePulse (oReleasePulse),
    .oShortClick   (oShortClick),
    .oLongPress    (oLongPress)
  );

  initial clk_48MHz = 1'b0;
  always #5 clk_48MHz = ~clk_48MHz;

  // Output vector order: {pressed, press, release, short, long}
  task automatic checkOutput(input string tag, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {oPressed, oPressPulse, oReleasePulse, oShortClick, oLongPress};
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic applyStimulus(input logic key);
    iKEY = key;
  endtask

  // Advance n rising edges, sampling outputs at each following falling edge.
  task automatic runChecked(input string tag, input int n, input logic [4:0] expected);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_48MHz);
      @(negedge clk_48MHz);
      checkOutput($sformatf("%s[%0d]", tag, i), expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    iKEY  = 1'b1;
    repeat (3) @(negedge clk_48MHz);
    checkOutput("reset", 5'b00000);
    rst_n = 1'b1;
    runChecked("idle", 5, 5'b00000);

    applyStimulus(1'b0);
    runChecked("t1_db", 10, 5'b00000);
    runChecked("t1_press", 1, 5'b11000);
    runChecked("t1_hold", 29, 5'b10000);
    applyStimulus(1'b1);
    runChecked("t1_rdb", 10, 5'b10000);
    runChecked("t1_release", 1, 5'b00110);
    runChecked("t1_after", 3, 5'b00000);

    applyStimulus(1'b0);
    runChecked("t2_low", 5, 5'b00000);
    applyStimulus(1'b1);
    runChecked("t2_high", 3, 5'b00000);
    applyStimulus(1'b0);
    runChecked("t2_db", 10, 5'b00000);
    runChecked("t2_press", 1, 5'b11000);
    runChecked("t2_hold", 5, 5'b10000);
    applyStimulus(1'b1);
    runChecked("t2_rdb", 10, 5'b10000);
    runChecked("t2_release", 1, 5'b00110);
    runChecked("t2_after", 3, 5'b00000);

    applyStimulus(1'b0);
    runChecked("t3_glitch", 7, 5'b00000);
    applyStimulus(1'b1);
    runChecked("t3_after", 12, 5'b00000);

    applyStimulus(1'b0);
    runChecked("t4_db", 10, 5'b00000);
    runChecked("t4_press", 1, 5'b11000);
    runChecked("t4_hold", 63, 5'b10000);
    runChecked("t4_long", 1, 5'b10001);
    runChecked("t4_held", 25, 5'b10000);
    applyStimulus(1'b1);
    runChecked("t4_rdb", 10, 5'b10000);
    runChecked("t4_release", 1, 5'b00100);
    runChecked("t4_after", 3, 5'b00000);

    // Bounce freezes hold_cnt for 5 edges, pushing long-press from edge 75 to 80
    applyStimulus(1'b0);
    runChecked("t5_db", 10, 5'b00000);
    runChecked("t5_press", 1, 5'b11000);
    runChecked("t5_hold", 10, 5'b10000);
    applyStimulus(1'b1);
    runChecked("t5_bounce", 4, 5'b10000);
    applyStimulus(1'b0);
    runChecked("t5_resume", 54, 5'b10000);
    runChecked("t5_long", 1, 5'b10001);
    applyStimulus(1'b1);
    runChecked("t5_rdb", 10, 5'b10000);
    runChecked("t5_release", 1, 5'b00100);
    runChecked("t5_after", 3, 5'b00000);

    // Release reaches the FSM exactly on the hold terminal cycle
    applyStimulus(1'b0);
    runChecked("tb_db", 10, 5'b00000);
    runChecked("tb_press", 1, 5'b11000);
    runChecked("tb_hold", 61, 5'b10000);
    applyStimulus(1'b1);
    runChecked("tb_rdb", 10, 5'b10000);
    runChecked("tb_release", 1, 5'b00110);
    runChecked("tb_after", 3, 5'b00000);

    applyStimulus(1'b0);
    runChecked("t6_db", 10, 5'b00000);
    runChecked("t6_press", 1, 5'b11000);
    runChecked("t6_hold", 5, 5'b10000);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_reset", 5'b00000);
    runChecked("t6_in_reset", 3, 5'b00000);
    rst_n = 1'b1;
    runChecked("t6_db", 10, 5'b00000);
    runChecked("t6_repress", 1, 5'b11000);
    runChecked("t6_hold2", 2, 5'b10000);
    applyStimulus(1'b1);
    runChecked("t6_rdb", 10, 5'b10000);
    runChecked("t6_release", 1, 5'b00110);
    runChecked("t6_after", 3, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
